// File: rtl/bitwise_reduce_pipe.sv
// bitwise_reduce_pipe
// Two-stage valid/ready pipeline that reduces PORT_NUM operands of WIDTH bits
// with AND, OR, XOR or XNOR. Stage S1 captures operands and mode; stage S2
// holds the computed result that drives out_data/out_valid.
// Optional feature: define BITWISE_REDUCE_MASK_EN to add in_mask, a per-port
// participation mask captured together with in_data.
module bitwise_reduce_pipe #(
  parameter int PORT_NUM = 8,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORT_NUM*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
`ifdef BITWISE_REDUCE_MASK_EN
  input  logic [PORT_NUM-1:0]       in_mask,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_XNOR = 2'b11
  } mode_e;

  // Stage 1: captured operands and mode
  logic                      s1_valid_q, s1_valid_d;
  logic [PORT_NUM*WIDTH-1:0] s1_data_q,  s1_data_d;
  mode_e                     s1_mode_q,  s1_mode_d;
  logic [PORT_NUM-1:0]       s1_part_q,  s1_part_d;

  // Stage 2: computed result
  logic                      s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]          s2_data_q,  s2_data_d;

  logic                      in_fire;
  logic                      s2_load;
  logic [PORT_NUM-1:0]       in_part;
  logic [WIDTH-1:0]          result;

`ifdef BITWISE_REDUCE_MASK_EN
  assign in_part = in_mask;
`else
  assign in_part = '1;
`endif

  // S1 can take a new transaction whenever some stage frees up this cycle;
  // held low throughout reset so nothing is accepted while state clears.
  assign in_ready = rst_n & (~s1_valid_q | ~s2_valid_q | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);

  assign out_data  = s2_data_q;
  assign out_valid = s2_valid_q;

  // Reduce the S1 operands; masked ports are skipped, which is the same as
  // contributing the identity element of the selected operation.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every variable a
    // default first, so no path leaves a value held and no latch is inferred.
    if (s1_mode_q == MODE_AND) result = '1;
    else                       result = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (s1_part_q[i]) begin
        case (s1_mode_q)
          MODE_AND: result = result & s1_data_q[i*WIDTH +: WIDTH];
          MODE_OR:  result = result | s1_data_q[i*WIDTH +: WIDTH];
          default:  result = result ^ s1_data_q[i*WIDTH +: WIDTH];
        endcase
      end
    end
    if (s1_mode_q == MODE_XNOR) result = ~result;
  end

  // Next-state for both stages: S1 loads on accept, empties when S2 takes it;
  // S2 loads from S1, empties when downstream takes it with nothing behind.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_part_d  = s1_part_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_mode_d  = mode_e'(in_mode);
      s1_part_d  = in_part;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = result;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking '<=' so every register samples
    // values from before the edge, independent of statement order.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // S1 payload registers.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; it is only consumed while
    // s1_valid_q is set, and dropping the reset keeps these as plain flops.
    s1_data_q <= s1_data_d;
    s1_mode_q <= s1_mode_d;
    s1_part_q <= s1_part_d;
  end

endmodule

// File: tb/tb_bitwise_reduce_pipe.sv
// Testbench for bitwise_reduce_pipe (PORT_NUM=8, WIDTH=8). Directed scenarios
// plus randomized valid/ready traffic checked against a per-bit counting model.
// Define BITWISE_REDUCE_MASK_EN to also exercise the participation mask.
module tb_bitwise_reduce_pipe;
  localparam int P = 8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [P*W-1:0] in_data;
  logic [1:0]     in_mode;
  logic [P-1:0]   in_mask;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;

  int compared   = 0;
  int mismatched = 0;

  bitwise_reduce_pipe #(.PORT_NUM(P), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_mode   (in_mode),
`ifdef BITWISE_REDUCE_MASK_EN
    .in_mask   (in_mask),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Every port carries the same value.
  function automatic logic [P*W-1:0] fill(input logic [W-1:0] v);
    logic [P*W-1:0] r;
    for (int i = 0; i < P; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [P*W-1:0] rand_data();
    logic [P*W-1:0] r;
    for (int i = 0; i < P; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  // Reference: per result bit, count participating ports and how many hold 1.
  // AND = all ones, OR = any one, XOR = odd count, XNOR = even count.
  function automatic logic [W-1:0] ref_reduce(input logic [P*W-1:0] d,
                                              input logic [1:0] m,
                                              input logic [P-1:0] mk);
    logic [W-1:0] r;
    int ones, n;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      n    = 0;
      for (int i = 0; i < P; i++) begin
        if (mk[i]) begin
          n++;
          if (d[i*W + b]) ones++;
        end
      end
      case (m)
        2'b00:   r[b] = (ones == n);
        2'b01:   r[b] = (ones > 0);
        2'b10:   r[b] = (ones % 2 == 1);
        default: r[b] = (ones % 2 == 0);
      endcase
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mode = 2'b00; in_mask = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++;
    if (out_data !== 8'h00) begin mismatched++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_and();
    logic [P*W-1:0] d;
    d = fill(8'hFF);
    d[3*W +: W] = 8'h0F;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_mode = 2'b00; out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL and_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL and_early_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL and_out_valid: got %b want 1", out_valid); end
    compared++;
    if (out_data !== 8'h0F) begin mismatched++; $display("FAIL and_out_data: got %h want 0f", out_data); end
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL and_drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [P*W-1:0] d   [3];
    logic [1:0]     m   [3];
    logic [W-1:0]   exp [3];
    for (int i = 0; i < P; i++) d[0][i*W +: W] = 8'(1 << i);
    d[1] = fill(8'hA5); d[2] = fill(8'hA5);
    m[0] = 2'b01; m[1] = 2'b10; m[2] = 2'b11;
    exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin in_valid = 1'b1; in_data = d[c]; in_mode = m[c]; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid[%0d]: got %b want 1", c - 2, out_valid); end
        compared++;
        if (out_data !== exp[c-2]) begin mismatched++; $display("FAIL b2b_data[%0d]: got %h want %h", c - 2, out_data, exp[c-2]); end
      end else begin
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_valid[c%0d]: got %b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [P*W-1:0] d [3];
    logic [1:0]     m [3];
    logic [W-1:0]   exp [3];
    for (int t = 0; t < 3; t++) begin
      d[t] = rand_data(); m[t] = 2'($urandom);
      exp[t] = ref_reduce(d[t], m[t], '1);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 4);
      if (c < 3) begin in_valid = 1'b1; in_data = d[c]; in_mode = m[c]; end
      else if (c >= 5) in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 3) begin
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_stall_ready[c%0d]: got %b want 0", c, in_ready); end
        compared++;
        if (out_data !== exp[0] || out_valid !== 1'b1) begin
          mismatched++; $display("FAIL bp_hold[c%0d]: got %b/%h want 1/%h", c, out_valid, out_data, exp[0]);
        end
      end else if (c >= 4 && c <= 6) begin
        compared++;
        if (out_data !== exp[c-4] || out_valid !== 1'b1) begin
          mismatched++; $display("FAIL bp_drain[%0d]: got %b/%h want 1/%h", c - 4, out_valid, out_data, exp[c-4]);
        end
      end else if (c == 7) begin
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_extra_valid: got %b want 0", out_valid); end
      end else begin
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_fill_ready[c%0d]: got %b want 1", c, in_ready); end
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c < 2) begin in_valid = 1'b1; in_data = rand_data(); in_mode = 2'($urandom); end
      else if (c == 2) begin in_valid = 1'b0; rst_n = 1'b0; end
      else if (c == 3) begin
        rst_n = 1'b1; in_valid = 1'b1; in_data = fill(8'h3C); in_mode = 2'b00; out_ready = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clk);
      case (c)
        2: begin
          compared++;
          if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
        end
        3: begin
          compared++;
          if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            mismatched++; $display("FAIL rmid_cleared: got %b/%h want 0/00", out_valid, out_data);
          end
        end
        4: begin
          compared++;
          if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_latency: got %b want 0", out_valid); end
        end
        5: begin
          compared++;
          if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            mismatched++; $display("FAIL rmid_result: got %b/%h want 1/3c", out_valid, out_data);
          end
        end
        6: begin
          compared++;
          if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_leftover: got %b want 0", out_valid); end
        end
        default: ;
      endcase
    end
  endtask

`ifdef BITWISE_REDUCE_MASK_EN
  task automatic test_mask();
    logic [P*W-1:0] d [3];
    logic [1:0]     m [3];
    logic [P-1:0]   k [3];
    logic [W-1:0]   exp [3];
    d[0] = fill(8'hFF); d[0][3*W +: W] = 8'h00; m[0] = 2'b00; k[0] = 8'hF7; exp[0] = 8'hFF;
    d[1] = rand_data(); m[1] = 2'b01; k[1] = 8'h00; exp[1] = 8'h00;
    d[2] = rand_data(); m[2] = 2'b00; k[2] = 8'h00; exp[2] = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin in_valid = 1'b1; in_data = d[c]; in_mode = m[c]; in_mask = k[c]; end
      else begin in_valid = 1'b0; in_mask = '1; end
      @(negedge clk);
      if (c >= 2) begin
        compared++;
        if (out_valid !== 1'b1 || out_data !== exp[c-2]) begin
          mismatched++; $display("FAIL mask[%0d]: got %b/%h want 1/%h", c - 2, out_valid, out_data, exp[c-2]);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] q[$];
    logic         exp_ready;
    for (int n = 0; n < 420; n++) begin
      @(posedge clk); #1;
      if (n < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        in_data   = rand_data();
        in_mode   = 2'($urandom);
`ifdef BITWISE_REDUCE_MASK_EN
        in_mask   = P'($urandom);
`endif
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      @(negedge clk);
      exp_ready = (q.size() < 2) || out_ready;
      compared++;
      if (in_ready !== exp_ready) begin
        mismatched++; $display("FAIL rand_in_ready[n%0d]: got %b want %b", n, in_ready, exp_ready);
      end
      if (out_valid === 1'b1) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++; $display("FAIL rand_spurious[n%0d]: got %h want no output", n, out_data);
        end else if (out_data !== q[0]) begin
          mismatched++; $display("FAIL rand_data[n%0d]: got %h want %h", n, out_data, q[0]);
        end
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(ref_reduce(in_data, in_mode, in_mask));
    end
    in_mask = '1;
    compared++;
    if (q.size() != 0) begin
      mismatched++; $display("FAIL rand_lost: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef BITWISE_REDUCE_MASK_EN
    test_mask();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
